clb_param: RTL

//  Parametrised successor CLB tile: one LUT_K-input LUT plus optional output FF, routed to 4 sides (up/down/right/left).

---
 rtl/clb_param_pkg.sv | 40 ++++
 rtl/clb_param_if.sv | 24 ++
 rtl/clb_param_cfg_loader.sv | 79 +++++++
 rtl/clb_param.sv | 77 +++++++
 4 files changed

// File: rtl/clb_param_pkg.sv
// Shared types and sizing helpers for the parametrised CLB tile and its config loader.
package clb_pkg;

  typedef enum logic [1:0] {
    SIDE_UP    = 2'd0,
    SIDE_DOWN  = 2'd1,
    SIDE_RIGHT = 2'd2,
    SIDE_LEFT  = 2'd3
  } clb_side_e;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_LOAD,
    CFG_COMMIT
  } cfg_state_e;

  // Config word: in_sel (2 bits per LUT input), out_sel[3:0], reg_en, LUT table.
  function automatic int cfg_width(input int lut_k);
    return 2 * lut_k + 4 + 1 + (1 << lut_k);
  endfunction

  function automatic int cfg_beats(input int lut_k, input int chunk);
    return (cfg_width(lut_k) + chunk - 1) / chunk;
  endfunction

  // sides is packed {left, right, down, up} so the enum value is the bit position.
  function automatic logic side_bit(input logic [3:0] sides, input clb_side_e sel);
    logic b;
    b = sides[0];
    case (sel)
      SIDE_UP:    b = sides[0];
      SIDE_DOWN:  b = sides[1];
      SIDE_RIGHT: b = sides[2];
      SIDE_LEFT:  b = sides[3];
      default:    b = sides[0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/clb_param_if.sv
// Chunked config stream between the fabric config controller and a CLB tile.
// CLB_READBACK_EN adds the active-config readback signal.
interface clb_param_if #(
  parameter int CHUNK = 8,
  parameter int CFG_W = 29
);

  logic             valid;
  logic             sof;
  logic [CHUNK-1:0] data;
  logic             ready;
  logic             done;

`ifdef CLB_READBACK_EN
  logic [CFG_W-1:0] rdata;

  modport master (output valid, sof, data, input ready, done, rdata);
  modport slave  (input valid, sof, data, output ready, done, rdata);
`else
  modport master (output valid, sof, data, input ready, done);
  modport slave  (input valid, sof, data, output ready, done);
`endif

endinterface

// File: rtl/clb_param_cfg_loader.sv
// Config loader: collects MSB-first beats into a shadow word and commits it atomically.
// CLB_READBACK_EN drives the active config back onto the interface.
module clb_cfg_loader
  import clb_pkg::*;
#(
  parameter int CFG_CHUNK = 8,
  parameter int CFG_W     = 29,
  parameter int BEATS     = 4
) (
  input  logic             clk,
  input  logic             rst,
  clb_param_if.slave       cfg,
  output logic [CFG_W-1:0] active
);

  localparam int CNT_W = $clog2(BEATS + 1);

  cfg_state_e       state;
  cfg_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CFG_W-1:0] shadow;
  logic             done_q;
  logic             xfer;
  logic             last_beat;

  assign xfer = cfg.valid & cfg.ready;
  // A sof beat is only the final beat when the whole word fits in one chunk.
  assign last_beat = cfg.sof ? (BEATS == 1) : (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CFG_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CFG_IDLE:   if (xfer && cfg.sof) state_nxt = last_beat ? CFG_COMMIT : CFG_LOAD;
      CFG_LOAD:   if (xfer && last_beat) state_nxt = CFG_COMMIT;
      CFG_COMMIT: state_nxt = CFG_IDLE;
      default:    state_nxt = CFG_IDLE;
    endcase
  end

  always_comb begin
    cfg.ready = (state != CFG_COMMIT);
  end

  // Padding bits of beat 0 fall off the top of the shadow as later beats shift in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      shadow <= '0;
      active <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == CFG_COMMIT);
      if (state == CFG_COMMIT) begin
        active <= shadow;
        cnt    <= '0;
      end else if (xfer) begin
        if (cfg.sof) begin
          shadow <= CFG_W'(cfg.data);
          cnt    <= CNT_W'(1);
        end else if (state == CFG_LOAD) begin
          shadow <= CFG_W'({shadow, cfg.data});
          cnt    <= cnt + 1'b1;
        end
      end
    end
  end

  assign cfg.done = done_q;

`ifdef CLB_READBACK_EN
  assign cfg.rdata = active;
`endif

endmodule

// File: rtl/clb_param.sv
// Parametrised CLB tile: LUT_K-input LUT, optional output FF, four-side routing.
// Optional readback of the active config is enabled with CLB_READBACK_EN.
module clb_param
  import clb_pkg::*;
#(
  parameter int LUT_K     = 4,
  parameter int CFG_CHUNK = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       right_i,
  input  logic       left_i,
  output logic       up_o,
  output logic       down_o,
  output logic       right_o,
  output logic       left_o,
  clb_param_if.slave cfg
);

  localparam int CFG_W = cfg_width(LUT_K);
  localparam int BEATS = cfg_beats(LUT_K, CFG_CHUNK);
  localparam int LUT_N = 1 << LUT_K;

  typedef struct packed {
    logic [LUT_K-1:0][1:0] in_sel;
    logic [3:0]            out_sel;
    logic                  reg_en;
    logic [LUT_N-1:0]      lut;
  } clb_cfg_t;

  logic [CFG_W-1:0] active;
  clb_cfg_t         active_cfg;
  logic [3:0]       sides;
  logic [LUT_K-1:0] lut_idx;
  logic             lut_res;
  logic             lut_ff;
  logic             lut_q;

  clb_cfg_loader #(
    .CFG_CHUNK (CFG_CHUNK),
    .CFG_W     (CFG_W),
    .BEATS     (BEATS)
  ) u_loader (
    .clk    (clk_i),
    .rst    (rst_i),
    .cfg    (cfg),
    .active (active)
  );

  assign active_cfg = clb_cfg_t'(active);
  assign sides      = {left_i, right_i, down_i, up_i};

  always_comb begin
    lut_idx = '0;
    for (int i = 0; i < LUT_K; i++) begin
      lut_idx[i] = side_bit(sides, clb_side_e'(active_cfg.in_sel[i]));
    end
  end

  assign lut_res = active_cfg.lut[lut_idx];

  // The FF samples every edge regardless of reg_en, so it is not disturbed by commits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lut_ff <= 1'b0;
    else       lut_ff <= lut_res;
  end

  assign lut_q = active_cfg.reg_en ? lut_ff : lut_res;

  assign up_o    = active_cfg.out_sel[3] ? lut_q : down_i;
  assign down_o  = active_cfg.out_sel[2] ? lut_q : up_i;
  assign right_o = active_cfg.out_sel[1] ? lut_q : left_i;
  assign left_o  = active_cfg.out_sel[0] ? lut_q : right_i;

endmodule
